// File: rtl/count_event_logger_pkg.sv
// rtl/count_event_logger_pkg.sv - shared constants and entry packing for the count event logger
// Contents: event width, default geometry, log entry field positions, pack_entry().
package count_event_logger_pkg;

  localparam int EV_W       = 3;
  localparam int ENTRY_W    = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_TS_W   = 13;

  // Log entry layout: [31:24] count1, [23:16] count2, [15:13] mask, [12:0] timestamp
  localparam int TS_LSB     = 0;
  localparam int TS_FIELD_W = 13;
  localparam int MASK_LSB   = 13;
  localparam int C2_LSB     = 16;
  localparam int C1_LSB     = 24;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [7:0]            c1,
    input logic [7:0]            c2,
    input logic [EV_W-1:0]       mask,
    input logic [TS_FIELD_W-1:0] ts
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[C1_LSB +: 8]          = c1;
    e[C2_LSB +: 8]          = c2;
    e[MASK_LSB +: EV_W]     = mask;
    e[TS_LSB +: TS_FIELD_W] = ts;
    return e;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - first-word-fall-through storage for logged events
// Ports: sys_clk, rst_n (async, active low), push/pop/clear strobes, wr_data in,
//        rd_data (head entry, 0 when empty), level, full, empty.
module event_fifo
  import count_event_logger_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = ENTRY_W
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push
  // when it is popped at the same time.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible through level.
  always_ff @(posedge sys_clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/count_event_logger.sv
// rtl/count_event_logger.sv - timestamped logger of counter match events
// Ports: sys_clk, rst_n (async, active low), ev_in[2:0] event levels, count1/count2
//        sampled values, log_en, pop, clear; rd_data head entry, empty, full, level,
//        overflow (sticky), drop_cnt (saturating).
module count_event_logger
  import count_event_logger_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TS_W  = DEF_TS_W
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic [EV_W-1:0]          ev_in,
  input  logic [7:0]               count1,
  input  logic [7:0]               count2,
  input  logic                     log_en,
  input  logic                     pop,
  input  logic                     clear,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  logic [EV_W-1:0]       ev_q;
  logic [EV_W-1:0]       rise;
  logic [TS_W-1:0]       ts;
  logic [TS_FIELD_W-1:0] ts_field;
  logic                  push;
  logic                  drop;
  logic [ENTRY_W-1:0]    wr_data;

  assign rise     = ev_in & ~ev_q;
  assign push     = log_en && (rise != '0);
  assign ts_field = TS_FIELD_W'(ts);
  assign wr_data  = pack_entry(count1, count2, rise, ts_field);

  // A full FIFO only loses the entry when nothing is popped on the same edge.
  assign drop = push && full && !pop;

  // ev_q keeps tracking ev_in through clear and while logging is disabled,
  // so a level that was already high never produces a late entry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q     <= '0;
      ts       <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ev_q <= ev_in;
      if (clear) begin
        ts       <= '0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        ts <= ts + TS_W'(1);
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_count_event_logger.sv
// tb/tb_count_event_logger.sv - directed vector bench for count_event_logger
module tb_count_event_logger;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ev_in;
  logic [7:0]  count1;
  logic [7:0]  count2;
  logic        log_en;
  logic        pop;
  logic        clear;
  logic [31:0] rd_data;
  logic        empty;
  logic        full;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  count_event_logger #(.DEPTH(16), .TS_W(13)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .ev_in    (ev_in),
    .count1   (count1),
    .count2   (count2),
    .log_en   (log_en),
    .pop      (pop),
    .clear    (clear),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  typedef struct {
    logic [2:0]  ev;
    logic [7:0]  c1;
    logic [7:0]  c2;
    logic        en;
    logic        pp;
    logic        clr;
    logic        e_empty;
    logic [4:0]  e_level;
    logic [31:0] e_rd;
    logic        e_ovf;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [2:0] ev, input logic [7:0] c1, input logic [7:0] c2,
                              input logic en, input logic pp, input logic clr,
                              input logic emp, input logic [4:0] lvl, input logic [31:0] rd,
                              input logic ovf, input logic [7:0] drp);
    vec_t v;
    v.ev = ev; v.c1 = c1; v.c2 = c2; v.en = en; v.pp = pp; v.clr = clr;
    v.e_empty = emp; v.e_level = lvl; v.e_rd = rd; v.e_ovf = ovf; v.e_drop = drp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ev, input logic [7:0] c1, input logic [7:0] c2,
                       input logic en, input logic pp, input logic clr);
    @(negedge sys_clk);
    ev_in = ev; count1 = c1; count2 = c2; log_en = en; pop = pp; clear = clr;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ev_in = '0; count1 = '0; count2 = '0; log_en = 1'b0; pop = 1'b0; clear = 1'b0;
    #12;
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset level", level, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset overflow", overflow, 0);
    chk("reset drop_cnt", drop_cnt, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Vector i after the clear in vector 0 captures timestamp i-1.
    add(3'b000, 8'h00, 8'h00, 0, 0, 1, 1, 0, 32'h0,        0, 0);
    add(3'b001, 8'h12, 8'h34, 1, 0, 0, 0, 1, 32'h12342000, 0, 0);
    for (int k = 0; k < 9; k++)
      add(3'b001, 8'h12, 8'h34, 1, 0, 0, 0, 1, 32'h12342000, 0, 0);
    add(3'b000, 8'h12, 8'h34, 1, 0, 0, 0, 1, 32'h12342000, 0, 0);
    add(3'b101, 8'hAB, 8'hCD, 1, 0, 0, 0, 2, 32'h12342000, 0, 0);
    add(3'b101, 8'hAB, 8'hCD, 1, 1, 0, 0, 1, 32'hABCDA00B, 0, 0);
    add(3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 1, 32'hABCDA00B, 0, 0);
    add(3'b010, 8'h00, 8'h00, 0, 0, 0, 0, 1, 32'hABCDA00B, 0, 0);
    add(3'b010, 8'h00, 8'h00, 1, 0, 0, 0, 1, 32'hABCDA00B, 0, 0);
    add(3'b000, 8'h00, 8'h00, 0, 1, 0, 1, 0, 32'h0,        0, 0);
    add(3'b000, 8'h00, 8'h00, 0, 1, 0, 1, 0, 32'h0,        0, 0);
    add(3'b100, 8'hFF, 8'h01, 1, 0, 0, 0, 1, 32'hFF018012, 0, 0);
    add(3'b011, 8'h11, 8'h22, 1, 1, 1, 1, 0, 32'h0,        0, 0);
    add(3'b011, 8'h00, 8'h00, 1, 0, 0, 1, 0, 32'h0,        0, 0);
    add(3'b111, 8'h5A, 8'hA5, 1, 0, 0, 0, 1, 32'h5AA58001, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].ev, vecs[i].c1, vecs[i].c2, vecs[i].en, vecs[i].pp, vecs[i].clr);
      chk($sformatf("v%0d rd_data", i), rd_data, vecs[i].e_rd);
      chk($sformatf("v%0d level", i), level, vecs[i].e_level);
      chk($sformatf("v%0d empty", i), empty, vecs[i].e_empty);
      chk($sformatf("v%0d overflow", i), overflow, vecs[i].e_ovf);
      chk($sformatf("v%0d drop_cnt", i), drop_cnt, vecs[i].e_drop);
    end

    // Fill to full, overflow by one, then push+pop while full.
    drive(3'b000, 8'h00, 8'h00, 0, 0, 1);
    for (int i = 0; i < 17; i++) begin
      drive(3'b001, 8'(i), 8'h77, 1, 0, 0);
      if (i == 15) begin
        chk("fill full", full, 1);
        chk("fill level", level, 16);
        chk("fill overflow", overflow, 0);
      end
      drive(3'b000, 8'h00, 8'h00, 1, 0, 0);
    end
    chk("ovf full", full, 1);
    chk("ovf level", level, 16);
    chk("ovf overflow", overflow, 1);
    chk("ovf drop_cnt", drop_cnt, 1);
    chk("ovf head", rd_data[31:13], {8'h00, 8'h77, 3'b001});
    drive(3'b001, 8'h40, 8'h77, 1, 1, 0);
    chk("pushpop level", level, 16);
    chk("pushpop drop_cnt", drop_cnt, 1);
    chk("pushpop head", rd_data[31:13], {8'h01, 8'h77, 3'b001});
    drive(3'b000, 8'h00, 8'h00, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      drive(3'b001, 8'h99, 8'h99, 1, 0, 0);
      drive(3'b000, 8'h00, 8'h00, 1, 0, 0);
    end
    chk("sat drop_cnt", drop_cnt, 8'hFF);
    chk("sat level", level, 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain %0d", k), rd_data[31:13],
          {(k < 15) ? 8'(k + 1) : 8'h40, 8'h77, 3'b001});
      drive(3'b000, 8'h00, 8'h00, 0, 1, 0);
    end
    chk("drain empty", empty, 1);
    chk("drain rd_data", rd_data, 0);

    // Asynchronous reset mid-run, with an event level held across deassertion.
    drive(3'b001, 8'h21, 8'h43, 1, 0, 0);
    drive(3'b000, 8'h00, 8'h00, 1, 0, 0);
    drive(3'b001, 8'h21, 8'h43, 1, 0, 0);
    chk("pre-rst level", level, 2);
    @(negedge sys_clk);
    #2;
    rst_n = 1'b0;
    ev_in = 3'b001; count1 = 8'h66; count2 = 8'h99; log_en = 1'b1;
    #1;
    chk("async rst empty", empty, 1);
    chk("async rst rd_data", rd_data, 0);
    chk("async rst level", level, 0);
    chk("async rst overflow", overflow, 0);
    chk("async rst drop_cnt", drop_cnt, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("post-rst level", level, 1);
    chk("post-rst entry", rd_data, 32'h66992000);
    drive(3'b001, 8'h66, 8'h99, 1, 0, 0);
    chk("post-rst held level", level, 1);

    // Timestamp wrap: captures at ts=1FFF and ts=0000.
    drive(3'b000, 8'h00, 8'h00, 0, 0, 1);
    drive(3'b000, 8'h00, 8'h00, 0, 0, 0);
    repeat (8190) @(posedge sys_clk);
    drive(3'b001, 8'hC3, 8'h3C, 1, 0, 0);
    drive(3'b011, 8'hC3, 8'h3C, 1, 0, 0);
    drive(3'b000, 8'h00, 8'h00, 0, 0, 0);
    chk("wrap level", level, 2);
    chk("wrap ts 1FFF", rd_data, 32'hC33C3FFF);
    drive(3'b000, 8'h00, 8'h00, 0, 1, 0);
    chk("wrap ts 0000", rd_data, 32'hC33C4000);
    drive(3'b000, 8'h00, 8'h00, 0, 1, 0);
    chk("wrap empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
